// File: rtl/datapath_pipe.sv
// datapath_pipe: two-stage (RD -> EX) pipelined register-file datapath.
//   RD: operand fetch, constant mux (MB); DI is sampled here.
//   EX: function unit, BusD mux (MD), write-back, status flags, memory bus.
// Optional feature macro: DATAPATH_PIPE_FWD_EN
//   defined   -> EX write-back value is bypassed into RD operand fetch.
//   undefined -> RD sees the register file before the EX write (one bubble
//                must separate dependent micro-ops).
module datapath_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREG  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     op_valid,
    input  logic [$clog2(NREG)-1:0]  AA,
    input  logic [$clog2(NREG)-1:0]  BA,
    input  logic [$clog2(NREG)-1:0]  DA,
    input  logic [3:0]               FS,
    input  logic [WIDTH-1:0]         CI,
    input  logic [WIDTH-1:0]         DI,
    input  logic                     LE,
    input  logic                     MD,
    input  logic                     MB,
    output logic [WIDTH-1:0]         BusD,
    output logic [WIDTH-1:0]         Address_out,
    output logic [WIDTH-1:0]         Data_out,
    output logic                     ex_valid,
    output logic                     N,
    output logic                     Z,
    output logic                     C,
    output logic                     V
);

    localparam int unsigned RAW = $clog2(NREG);

    typedef enum logic [3:0] {
        FS_MOVA  = 4'b0000,
        FS_INC   = 4'b0001,
        FS_ADD   = 4'b0010,
        FS_ADDC  = 4'b0011,
        FS_ADDNB = 4'b0100,
        FS_SUB   = 4'b0101,
        FS_DEC   = 4'b0110,
        FS_MOVA2 = 4'b0111,
        FS_AND   = 4'b1000,
        FS_OR    = 4'b1001,
        FS_XOR   = 4'b1010,
        FS_NOT   = 4'b1011,
        FS_MOVB  = 4'b1100,
        FS_SHR   = 4'b1101,
        FS_SHL   = 4'b1110,
        FS_ROR   = 4'b1111
    } fs_e;

    // Register file
    logic [WIDTH-1:0] r_regs [NREG];

    // EX pipeline register
    logic [WIDTH-1:0] r_a_ex;
    logic [WIDTH-1:0] r_b_ex;
    logic [WIDTH-1:0] r_di_ex;
    fs_e              r_fs_ex;
    logic [RAW-1:0]   r_da_ex;
    logic             r_le_ex;
    logic             r_md_ex;
    logic             r_valid_ex;

    // Status flags
    logic r_n;
    logic r_z;
    logic r_c;
    logic r_v;

    // RD-stage operands
    logic [WIDTH-1:0] w_a_rd;
    logic [WIDTH-1:0] w_b_rd;

    // EX-stage function unit
    logic [WIDTH-1:0] w_add_y;
    logic             w_add_cin;
    logic [WIDTH:0]   w_sum;
    logic             w_add_ovf;
    logic [WIDTH-1:0] w_f;
    logic             w_c;
    logic             w_v;
    logic [WIDTH-1:0] w_busd;
    logic             w_wr;
    logic             w_flag_upd;

    assign w_wr       = r_valid_ex & r_le_ex;
    assign w_flag_upd = w_wr & ~r_md_ex;

    // RD operand fetch with B constant mux and optional EX->RD bypass
    always_comb begin
        w_a_rd = r_regs[AA];
        w_b_rd = MB ? CI : r_regs[BA];
`ifdef DATAPATH_PIPE_FWD_EN
        if (w_wr && (r_da_ex == AA)) begin
            w_a_rd = w_busd;
        end
        if (!MB && w_wr && (r_da_ex == BA)) begin
            w_b_rd = w_busd;
        end
`endif
    end

    // EX pipeline register: captures every cycle, bubbles included, so the
    // memory bus always shows the latched operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_ex     <= '0;
            r_b_ex     <= '0;
            r_di_ex    <= '0;
            r_fs_ex    <= FS_MOVA;
            r_da_ex    <= '0;
            r_le_ex    <= 1'b0;
            r_md_ex    <= 1'b0;
            r_valid_ex <= 1'b0;
        end else begin
            r_a_ex     <= w_a_rd;
            r_b_ex     <= w_b_rd;
            r_di_ex    <= DI;
            r_fs_ex    <= fs_e'(FS);
            r_da_ex    <= DA;
            r_le_ex    <= LE;
            r_md_ex    <= MD;
            r_valid_ex <= op_valid;
        end
    end

    // Adder second operand and carry-in; every arithmetic code is A + Y + cin
    always_comb begin
        w_add_y   = '0;
        w_add_cin = 1'b0;
        unique case (r_fs_ex)
            FS_INC:   begin w_add_y = '0;      w_add_cin = 1'b1; end
            FS_ADD:   begin w_add_y = r_b_ex;  w_add_cin = 1'b0; end
            FS_ADDC:  begin w_add_y = r_b_ex;  w_add_cin = 1'b1; end
            FS_ADDNB: begin w_add_y = ~r_b_ex; w_add_cin = 1'b0; end
            FS_SUB:   begin w_add_y = ~r_b_ex; w_add_cin = 1'b1; end
            FS_DEC:   begin w_add_y = '1;      w_add_cin = 1'b0; end
            default:  begin w_add_y = '0;      w_add_cin = 1'b0; end
        endcase
    end

    assign w_sum     = {1'b0, r_a_ex} + {1'b0, w_add_y} + {{WIDTH{1'b0}}, w_add_cin};
    assign w_add_ovf = (r_a_ex[WIDTH-1] == w_add_y[WIDTH-1]) &&
                       (w_sum[WIDTH-1] != r_a_ex[WIDTH-1]);

    // Function unit result and candidate C/V flags
    always_comb begin
        w_f = r_a_ex;
        w_c = 1'b0;
        w_v = 1'b0;
        unique case (r_fs_ex)
            FS_MOVA, FS_MOVA2: w_f = r_a_ex;
            FS_INC, FS_ADD, FS_ADDC, FS_ADDNB, FS_SUB, FS_DEC: begin
                w_f = w_sum[WIDTH-1:0];
                w_c = w_sum[WIDTH];
                w_v = w_add_ovf;
            end
            FS_AND:  w_f = r_a_ex & r_b_ex;
            FS_OR:   w_f = r_a_ex | r_b_ex;
            FS_XOR:  w_f = r_a_ex ^ r_b_ex;
            FS_NOT:  w_f = ~r_a_ex;
            FS_MOVB: w_f = r_b_ex;
            FS_SHR: begin
                w_f = {1'b0, r_b_ex[WIDTH-1:1]};
                w_c = r_b_ex[0];
            end
            FS_SHL: begin
                w_f = {r_b_ex[WIDTH-2:0], 1'b0};
                w_c = r_b_ex[WIDTH-1];
            end
            FS_ROR: begin
                w_f = {r_b_ex[0], r_b_ex[WIDTH-1:1]};
                w_c = r_b_ex[0];
            end
            default: w_f = r_a_ex;
        endcase
    end

    assign w_busd = r_md_ex ? r_di_ex : w_f;

    // Register-file write-back at the end of the EX cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regs <= '{default: '0};
        end else if (w_wr) begin
            r_regs[r_da_ex] <= w_busd;
        end
    end

    // Status flags follow only FU results that are actually written back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n <= 1'b0;
            r_z <= 1'b0;
            r_c <= 1'b0;
            r_v <= 1'b0;
        end else if (w_flag_upd) begin
            r_n <= w_f[WIDTH-1];
            r_z <= (w_f == '0);
            r_c <= w_c;
            r_v <= w_v;
        end
    end

    assign BusD        = w_busd;
    assign Address_out = r_a_ex;
    assign Data_out    = r_b_ex;
    assign ex_valid    = r_valid_ex;
    assign N           = r_n;
    assign Z           = r_z;
    assign C           = r_c;
    assign V           = r_v;

endmodule

// File: tb/tb_datapath_pipe.sv
// tb_datapath_pipe: directed table, hand-written corner sequences and random
// micro-ops against an arithmetic reference model; a second WIDTH=16/NREG=8
// instance covers the parameterised case.
`timescale 1ns/1ps
module tb_datapath_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit / 4-register instance
    logic       rst_n, op_valid, LE, MD, MB;
    logic [1:0] AA, BA, DA;
    logic [3:0] FS;
    logic [7:0] CI, DI, BusD, Address_out, Data_out;
    logic       ex_valid, N, Z, C, V;

    // 16-bit / 8-register instance
    logic        p_op_valid, p_LE, p_MD, p_MB;
    logic [2:0]  p_AA, p_BA, p_DA;
    logic [3:0]  p_FS;
    logic [15:0] p_CI, p_DI, p_BusD, p_Address_out, p_Data_out;
    logic        p_ex_valid, p_N, p_Z, p_C, p_V;

    datapath_pipe #(.WIDTH(8), .NREG(4)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .AA(AA), .BA(BA), .DA(DA),
        .FS(FS), .CI(CI), .DI(DI), .LE(LE), .MD(MD), .MB(MB), .BusD(BusD),
        .Address_out(Address_out), .Data_out(Data_out), .ex_valid(ex_valid),
        .N(N), .Z(Z), .C(C), .V(V)
    );

    datapath_pipe #(.WIDTH(16), .NREG(8)) dut16 (
        .clk(clk), .rst_n(rst_n), .op_valid(p_op_valid), .AA(p_AA), .BA(p_BA), .DA(p_DA),
        .FS(p_FS), .CI(p_CI), .DI(p_DI), .LE(p_LE), .MD(p_MD), .MB(p_MB), .BusD(p_BusD),
        .Address_out(p_Address_out), .Data_out(p_Data_out), .ex_valid(p_ex_valid),
        .N(p_N), .Z(p_Z), .C(p_C), .V(p_V)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       v;
        logic [1:0] aa, ba, da;
        logic [3:0] fs;
        logic [7:0] ci, di;
        logic       le, md, mb;
    } op_t;

    typedef struct {
        op_t        op;
        logic [7:0] exp_busd;
        logic       exp_exv;
        logic       chk_flags;
        logic [3:0] exp_nzcv;  // flags once this op has retired
    } vec_t;

    typedef struct {
        logic       v, le, md;
        logic [1:0] da;
        logic [7:0] a, b, busd;
        logic [3:0] nzcv;
    } ex_t;

    // Reference model state
    logic [7:0] mregs [4];
    logic [3:0] mflags;
    ex_t        pend;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic op_t mk(input logic v, input logic [1:0] aa, ba, da,
                               input logic [3:0] fs, input logic [7:0] ci, di,
                               input logic le, md, mb);
        op_t o;
        o.v = v; o.aa = aa; o.ba = ba; o.da = da; o.fs = fs;
        o.ci = ci; o.di = di; o.le = le; o.md = md; o.mb = mb;
        return o;
    endfunction

    function automatic vec_t mkv(input op_t o, input logic [7:0] busd, input logic exv,
                                 input logic chkf, input logic [3:0] nzcv);
        vec_t t;
        t.op = o; t.exp_busd = busd; t.exp_exv = exv; t.chk_flags = chkf; t.exp_nzcv = nzcv;
        return t;
    endfunction

    // Function unit from plain integer arithmetic; returns {C, V, F[7:0]}
    function automatic logic [9:0] ref_fu(input logic [3:0] fs, input logic [7:0] a, input logic [7:0] b);
        int ua = a;
        int ub = b;
        int sa = $signed(a);
        int sb = $signed(b);
        int u  = 0;
        int s  = 0;
        int f  = 0;
        bit arith = 0;
        bit c = 0;
        bit v = 0;
        case (fs)
            4'd0, 4'd7: f = ua;
            4'd1: begin u = ua + 1;              s = sa + 1;      arith = 1; end
            4'd2: begin u = ua + ub;             s = sa + sb;     arith = 1; end
            4'd3: begin u = ua + ub + 1;         s = sa + sb + 1; arith = 1; end
            4'd4: begin u = ua + (255 - ub);     s = sa - sb - 1; arith = 1; end
            4'd5: begin u = ua + (255 - ub) + 1; s = sa - sb;     arith = 1; end
            4'd6: begin u = ua + 255;            s = sa - 1;      arith = 1; end
            4'd8:  f = ua & ub;
            4'd9:  f = ua | ub;
            4'd10: f = ua ^ ub;
            4'd11: f = 255 - ua;
            4'd12: f = ub;
            4'd13: begin f = ub / 2;                  c = (ub % 2) == 1; end
            4'd14: begin f = (ub * 2) % 256;          c = ub >= 128; end
            default: begin f = ub / 2 + (ub % 2) * 128; c = (ub % 2) == 1; end
        endcase
        if (arith) begin
            f = u % 256;
            c = u >= 256;
            v = (s > 127) || (s < -128);
        end
        return {c, v, 8'(f)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mregs[i] = '0;
        mflags = '0;
        pend.v = 0; pend.le = 0; pend.md = 0; pend.da = '0;
        pend.a = '0; pend.b = '0; pend.busd = '0; pend.nzcv = 4'b0100;
    endtask

    // One issue cycle: model RD, retire the previous EX op, then compare EX outputs
    task automatic step(input op_t o);
        logic [7:0] a, b;
        logic [9:0] r;
        a = mregs[o.aa];
        b = o.mb ? o.ci : mregs[o.ba];
`ifdef DATAPATH_PIPE_FWD_EN
        if (pend.v && pend.le && pend.da == o.aa) a = pend.busd;
        if (!o.mb && pend.v && pend.le && pend.da == o.ba) b = pend.busd;
`endif
        if (pend.v && pend.le) begin
            mregs[pend.da] = pend.busd;
            if (!pend.md) mflags = pend.nzcv;
        end
        r = ref_fu(o.fs, a, b);
        pend.v = o.v; pend.le = o.le; pend.md = o.md; pend.da = o.da;
        pend.a = a; pend.b = b;
        pend.busd = o.md ? o.di : r[7:0];
        pend.nzcv = {r[7], r[7:0] == 8'h00, r[9], r[8]};

        op_valid = o.v; AA = o.aa; BA = o.ba; DA = o.da; FS = o.fs;
        CI = o.ci; DI = o.di; LE = o.le; MD = o.md; MB = o.mb;
        @(posedge clk);
        #1;
        check("mdl_exv",   ex_valid,    pend.v);
        check("mdl_busd",  BusD,        pend.busd);
        check("mdl_addr",  Address_out, pend.a);
        check("mdl_data",  Data_out,    pend.b);
        check("mdl_flags", {N, Z, C, V}, mflags);
    endtask

    task automatic step16(input logic v, input logic [2:0] aa, ba, da, input logic [3:0] fs,
                          input logic [15:0] di, input logic le, md);
        p_op_valid = v; p_AA = aa; p_BA = ba; p_DA = da; p_FS = fs;
        p_DI = di; p_LE = le; p_MD = md; p_MB = 1'b0; p_CI = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busd"},  BusD, 0);
        check({tag, "_addr"},  Address_out, 0);
        check({tag, "_data"},  Data_out, 0);
        check({tag, "_exv"},   ex_valid, 0);
        check({tag, "_flags"}, {N, Z, C, V}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    vec_t vecs [14];

    initial begin
        logic [7:0] hz;
        logic [3:0] hf;
`ifdef DATAPATH_PIPE_FWD_EN
        hz = 8'h06; hf = 4'b0000;
`else
        hz = 8'h80; hf = 4'b1001;
`endif
        //                 v aa ba da fs  ci     di    le md mb       busd  exv chk nzcv
        vecs[0]  = mkv(mk(1, 0, 0, 1, 0,  8'h00, 8'h7F, 1, 1, 0), 8'h7F, 1, 1, 4'b0000);
        vecs[1]  = mkv(mk(1, 0, 0, 2, 0,  8'h00, 8'h01, 1, 1, 0), 8'h01, 1, 1, 4'b0000);
        vecs[2]  = mkv(mk(0, 0, 0, 0, 0,  8'h00, 8'hAA, 1, 1, 0), 8'hAA, 0, 1, 4'b0000);
        vecs[3]  = mkv(mk(1, 1, 2, 3, 2,  8'h00, 8'h00, 1, 0, 0), 8'h80, 1, 1, 4'b1001);
        vecs[4]  = mkv(mk(1, 1, 1, 0, 5,  8'h00, 8'h00, 1, 0, 0), 8'h00, 1, 1, 4'b0110);
        vecs[5]  = mkv(mk(1, 3, 3, 0, 2,  8'h00, 8'h00, 0, 0, 0), 8'h00, 1, 1, 4'b0110);
        vecs[6]  = mkv(mk(1, 0, 0, 0, 13, 8'h81, 8'h00, 1, 0, 1), 8'h40, 1, 1, 4'b0010);
        vecs[7]  = mkv(mk(1, 0, 0, 0, 15, 8'h81, 8'h00, 1, 0, 1), 8'hC0, 1, 1, 4'b1010);
        vecs[8]  = mkv(mk(0, 3, 0, 3, 1,  8'h00, 8'h00, 1, 0, 0), 8'h81, 0, 1, 4'b1010);
        vecs[9]  = mkv(mk(1, 3, 0, 0, 0,  8'h00, 8'h00, 0, 0, 0), 8'h80, 1, 1, 4'b1010);
        vecs[10] = mkv(mk(1, 0, 0, 1, 0,  8'h00, 8'h05, 1, 1, 0), 8'h05, 1, 1, 4'b1010);
        vecs[11] = mkv(mk(1, 1, 0, 2, 1,  8'h00, 8'h00, 1, 0, 0), hz,    1, 1, hf);
        vecs[12] = mkv(mk(0, 0, 0, 0, 0,  8'h00, 8'h00, 0, 0, 0), 8'hC0, 0, 1, hf);
        vecs[13] = mkv(mk(1, 2, 0, 0, 0,  8'h00, 8'h00, 0, 0, 0), hz,    1, 0, hf);

        p_op_valid = 0; p_AA = '0; p_BA = '0; p_DA = '0; p_FS = '0;
        p_CI = '0; p_DI = '0; p_LE = 0; p_MD = 0; p_MB = 0;
        op_valid = 0; AA = '0; BA = '0; DA = '0; FS = '0;
        CI = '0; DI = '0; LE = 0; MD = 0; MB = 0;
        rst_n = 1'b0;
        model_reset();
        #2;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].op);
            check("vec_busd", BusD, vecs[i].exp_busd);
            check("vec_exv", ex_valid, vecs[i].exp_exv);
            if (i > 0 && vecs[i-1].chk_flags)
                check("vec_flags", {N, Z, C, V}, vecs[i-1].exp_nzcv);
        end

        // Reset while a load of R1 sits in EX: the write must be discarded
        step(mk(1, 0, 0, 1, 0, 8'h00, 8'h55, 1, 1, 0));
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(mk(1, 2'(k), 0, 0, 0, 8'h00, 8'h00, 0, 0, 0));
            check("rst_regread", BusD, 0);
        end

        // Back-to-back dependency right after reset
        step(mk(1, 0, 0, 1, 0, 8'h00, 8'h05, 1, 1, 0));
        step(mk(1, 1, 0, 2, 1, 8'h00, 8'h00, 1, 0, 0));
`ifdef DATAPATH_PIPE_FWD_EN
        check("hazard_busd", BusD, 8'h06);
`else
        check("hazard_busd", BusD, 8'h01);
`endif
        step(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0));
        step(mk(1, 2, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0));
`ifdef DATAPATH_PIPE_FWD_EN
        check("hazard_r2", BusD, 8'h06);
`else
        check("hazard_r2", BusD, 8'h01);
`endif

        // Random micro-ops against the model
        for (int n = 0; n < 400; n++) begin
            step(mk($urandom_range(0, 9) < 8, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 8'($urandom),
                    8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom)));
        end

        // WIDTH=16, NREG=8 instance
        step16(1, 0, 0, 1, 4'd0, 16'h7FFF, 1, 1);
        step16(1, 0, 0, 2, 4'd0, 16'h0001, 1, 1);
        step16(0, 0, 0, 0, 4'd0, 16'h0000, 0, 0);
        step16(1, 1, 2, 7, 4'd2, 16'h0000, 1, 0);
        check("w16_add_busd", p_BusD, 16'h8000);
        step16(0, 0, 0, 0, 4'd0, 16'h0000, 0, 0);
        check("w16_add_flags", {p_N, p_Z, p_C, p_V}, 4'b1001);
        step16(1, 7, 0, 0, 4'd0, 16'h0000, 0, 0);
        check("w16_r7", p_BusD, 16'h8000);
        step16(1, 1, 0, 0, 4'd1, 16'h0000, 0, 0);
        check("w16_inc_busd", p_BusD, 16'h8000);
        step16(0, 0, 0, 3, 4'd0, 16'h1234, 1, 1);
        check("w16_bubble_exv", p_ex_valid, 0);
        step16(1, 3, 0, 0, 4'd0, 16'h0000, 0, 0);
        check("w16_bubble_nowr", p_BusD, 16'h0000);
        check("w16_flags_hold", {p_N, p_Z, p_C, p_V}, 4'b1001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
